// File: rtl/fir_stream_src_if.sv
// Host-to-source and source-to-FIR-sink signal bundle for fir_stream_src.
//   host_data         : 6-bit sample or coefficient word from the host
//   host_is_coef      : 1 = host_data is a coefficient word, 0 = sample
//   host_valid        : host word offered
//   host_ready        : word accepted when host_valid and host_ready are both 1
//   x_n               : signed sample / coefficient word to the sink
//   s_axis_fir_tvalid : sample-stream valid to the sink
//   s_set_coeffs      : coefficient-load strobe to the sink
// Modport master is the host/observer side; modport slave is the source block.
interface fir_stream_src_if;
  logic [5:0] host_data;
  logic       host_is_coef;
  logic       host_valid;
  logic       host_ready;
  logic [5:0] x_n;
  logic       s_axis_fir_tvalid;
  logic       s_set_coeffs;

  modport master (
    output host_data,
    output host_is_coef,
    output host_valid,
    input  host_ready,
    input  x_n,
    input  s_axis_fir_tvalid,
    input  s_set_coeffs
  );

  modport slave (
    input  host_data,
    input  host_is_coef,
    input  host_valid,
    output host_ready,
    output x_n,
    output s_axis_fir_tvalid,
    output s_set_coeffs
  );
endinterface

// File: rtl/fir_stream_src.sv
// Stream source for a FIR filter sink. Host words are either samples, which are
// queued in a small FIFO and streamed out one per cycle, or coefficient words,
// which are collected into a burst of COEF_WORDS and then replayed to the sink
// with s_set_coeffs asserted. A pending coefficient burst takes priority over
// sample streaming; the stream always drops tvalid for at least one cycle
// before a coefficient load.
//
// Ports:
//   clk        : sole clock, rising edge
//   reset_n    : asynchronous active-low reset
//   bus        : fir_stream_src_if.slave (host handshake and sink outputs)
//   fifo_count : sample FIFO occupancy, 0..DEPTH
//   busy       : high while not idle or while a coefficient load is pending
//
// Parameters:
//   DEPTH      : sample FIFO depth, power of two, 2..8
//   COEF_WORDS : coefficient words per load burst
//
// Build option:
//   FIR_SRC_HOLD_LAST_EN : when defined, an empty FIFO during streaming holds
//   the last popped sample on x_n with tvalid kept high; when undefined the
//   stream drops tvalid, zeroes x_n and returns to idle.
module fir_stream_src #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned COEF_WORDS = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  fir_stream_src_if.slave bus,
  output logic [3:0]      fifo_count,
  output logic            busy
);

  localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IdxW   = $clog2(COEF_WORDS + 1);
  localparam int unsigned CoefAw = (COEF_WORDS > 1) ? $clog2(COEF_WORDS) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StCfg    = 2'd1;
  localparam logic [1:0] StCfgGap = 2'd2;
  localparam logic [1:0] StStream = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [5:0]      x_n_q, x_n_d;
  logic            tvalid_q, tvalid_d;
  logic            set_coeffs_q, set_coeffs_d;
  logic [IdxW-1:0] cfg_cnt_q, cfg_cnt_d;

  logic [5:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [3:0]      count_q;

  logic [5:0]      coef_q [COEF_WORDS];
  logic [IdxW-1:0] coef_idx_q;
  logic            cfg_pending_q;

  logic host_ready;
  logic push, coef_push, pop, cfg_done;
  logic fifo_empty;

  assign fifo_empty = (count_q == 4'd0);

  // Readiness depends on the kind of word offered; a full FIFO refuses samples
  // even when a pop happens on the same edge.
  always_comb begin
    if (bus.host_is_coef) begin
      host_ready = !cfg_pending_q && (coef_idx_q < IdxW'(COEF_WORDS));
    end else begin
      host_ready = (count_q < 4'(DEPTH));
    end
  end

  assign push      = bus.host_valid && host_ready && !bus.host_is_coef;
  assign coef_push = bus.host_valid && host_ready && bus.host_is_coef;

  // Next-state and next-output decode; the sink outputs are registered, so
  // each state's action appears on the sink from the following edge.
  always_comb begin
    state_d      = state_q;
    x_n_d        = 6'd0;
    tvalid_d     = 1'b0;
    set_coeffs_d = 1'b0;
    cfg_cnt_d    = cfg_cnt_q;
    pop          = 1'b0;
    cfg_done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        cfg_cnt_d = '0;
        if (cfg_pending_q) begin
          state_d = StCfg;
        end else if (!fifo_empty) begin
          state_d = StStream;
        end
      end
      StCfg: begin
        set_coeffs_d = 1'b1;
        x_n_d        = coef_q[cfg_cnt_q[CoefAw-1:0]];
        cfg_cnt_d    = cfg_cnt_q + IdxW'(1);
        if (cfg_cnt_q == IdxW'(COEF_WORDS - 1)) begin
          state_d = StCfgGap;
        end
      end
      StCfgGap: begin
        cfg_done = 1'b1;
        state_d  = StIdle;
      end
      StStream: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          x_n_d    = mem_q[rd_ptr_q];
          tvalid_d = 1'b1;
          // Finish the current word, then yield to the coefficient load via
          // idle so tvalid is low for at least one cycle before CFG.
          if (cfg_pending_q) begin
            state_d = StIdle;
          end
        end else if (cfg_pending_q) begin
          state_d = StIdle;
        end else begin
`ifdef FIR_SRC_HOLD_LAST_EN
          x_n_d    = x_n_q;
          tvalid_d = 1'b1;
`else
          state_d  = StIdle;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      x_n_q        <= 6'd0;
      tvalid_q     <= 1'b0;
      set_coeffs_q <= 1'b0;
      cfg_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      x_n_q        <= x_n_d;
      tvalid_q     <= tvalid_d;
      set_coeffs_q <= set_coeffs_d;
      cfg_cnt_q    <= cfg_cnt_d;
    end
  end

  // Sample FIFO control; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 4'd1;
        2'b01:   count_q <= count_q - 4'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.host_data;
    end
  end

  // Coefficient collection; the burst becomes pending on its last word and is
  // released once the load has been replayed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < COEF_WORDS; i++) begin
        coef_q[i] <= 6'd0;
      end
      coef_idx_q    <= '0;
      cfg_pending_q <= 1'b0;
    end else if (cfg_done) begin
      coef_idx_q    <= '0;
      cfg_pending_q <= 1'b0;
    end else if (coef_push) begin
      coef_q[coef_idx_q[CoefAw-1:0]] <= bus.host_data;
      coef_idx_q                     <= coef_idx_q + IdxW'(1);
      if (coef_idx_q == IdxW'(COEF_WORDS - 1)) begin
        cfg_pending_q <= 1'b1;
      end
    end
  end

  assign bus.host_ready        = host_ready;
  assign bus.x_n               = x_n_q;
  assign bus.s_axis_fir_tvalid = tvalid_q;
  assign bus.s_set_coeffs      = set_coeffs_q;
  assign fifo_count            = count_q;
  assign busy                  = (state_q != StIdle) || cfg_pending_q;

endmodule

// File: tb/tb_fir_stream_src.sv
// Bench for fir_stream_src: directed host traffic, a queue-based reference
// model checked against the DUT every cycle, and literal expectations for the
// key scenarios (latency, coefficient burst, backpressure, mid-burst reset).
module tb_fir_stream_src;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned COEF_WORDS = 3;

  logic       clk;
  logic       reset_n;
  logic [3:0] fifo_count;
  logic       busy;

  fir_stream_src_if bus ();

  fir_stream_src #(
    .DEPTH      (DEPTH),
    .COEF_WORDS (COEF_WORDS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .fifo_count (fifo_count),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [5:0] x;
    logic       v;
    logic       s;
    logic       gap;
  } step_t;

  logic [5:0] m_q [$];          // queued samples
  logic [5:0] m_coef [COEF_WORDS];
  int         m_ncoef;
  bit         m_pend;
  bit         m_stream;
  step_t      m_plan [$];       // scheduled coefficient-load output cycles
  logic [5:0] m_x;
  logic       m_v;
  logic       m_s;

  function automatic logic exp_ready();
    if (bus.host_is_coef) return !m_pend && (m_ncoef < COEF_WORDS);
    return m_q.size() < DEPTH;
  endfunction

  task automatic model_step();
    bit    acc_s;
    bit    acc_c;
    step_t st;
    if (!reset_n) begin
      m_q.delete();
      m_plan.delete();
      m_ncoef  = 0;
      m_pend   = 0;
      m_stream = 0;
      m_x      = 6'd0;
      m_v      = 1'b0;
      m_s      = 1'b0;
      for (int i = 0; i < COEF_WORDS; i++) m_coef[i] = 6'd0;
      return;
    end
    acc_s = bus.host_valid && !bus.host_is_coef && (m_q.size() < DEPTH);
    acc_c = bus.host_valid && bus.host_is_coef && !m_pend && (m_ncoef < COEF_WORDS);
    if (m_plan.size() > 0) begin
      st  = m_plan.pop_front();
      m_x = st.x;
      m_v = st.v;
      m_s = st.s;
      if (st.gap) begin
        m_pend  = 0;
        m_ncoef = 0;
      end
    end else if (!m_stream) begin
      m_x = 6'd0;
      m_v = 1'b0;
      m_s = 1'b0;
      if (m_pend) begin
        for (int i = 0; i < COEF_WORDS; i++)
          m_plan.push_back('{x: m_coef[i], v: 1'b0, s: 1'b1, gap: 1'b0});
        m_plan.push_back('{x: 6'd0, v: 1'b0, s: 1'b0, gap: 1'b1});
      end else if (m_q.size() > 0) begin
        m_stream = 1;
      end
    end else if (m_q.size() > 0) begin
      m_x = m_q.pop_front();
      m_v = 1'b1;
      m_s = 1'b0;
      if (m_pend) m_stream = 0;
    end else if (m_pend) begin
      m_x      = 6'd0;
      m_v      = 1'b0;
      m_s      = 1'b0;
      m_stream = 0;
    end else begin
`ifdef FIR_SRC_HOLD_LAST_EN
      m_v = 1'b1;
      m_s = 1'b0;
`else
      m_x      = 6'd0;
      m_v      = 1'b0;
      m_s      = 1'b0;
      m_stream = 0;
`endif
    end
    if (acc_s) m_q.push_back(bus.host_data);
    if (acc_c) begin
      m_coef[m_ncoef] = bus.host_data;
      m_ncoef++;
      if (m_ncoef == COEF_WORDS) m_pend = 1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      model_step();
    end
  end

  // ---------------- per-cycle compare and sink monitor ----------------
  logic [5:0] obs_v [$];
  logic [5:0] obs_c [$];

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        check("x_n", 32'(bus.x_n), 32'(m_x));
        check("tvalid", 32'(bus.s_axis_fir_tvalid), 32'(m_v));
        check("set_coeffs", 32'(bus.s_set_coeffs), 32'(m_s));
        check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        check("busy", 32'(busy), 32'(m_stream || (m_plan.size() > 0) || m_pend));
        check("host_ready", 32'(bus.host_ready), 32'(exp_ready()));
        check("excl", 32'(bus.s_set_coeffs & bus.s_axis_fir_tvalid), 32'd0);
        if (bus.s_axis_fir_tvalid) obs_v.push_back(bus.x_n);
        if (bus.s_set_coeffs) obs_c.push_back(bus.x_n);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic coef, input logic [5:0] d);
    int guard;
    guard            = 0;
    bus.host_valid   = 1'b1;
    bus.host_is_coef = coef;
    bus.host_data    = d;
    #1;
    while (!bus.host_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (!bus.host_ready) timeout_fail("push_accept");
    tick();
    bus.host_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    bus.host_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    obs_v.delete();
    obs_c.delete();
  endtask

  task automatic wait_set(output int n);
    n = 0;
    while (!bus.s_set_coeffs && n < 20) begin
      tick();
      n++;
    end
    if (!bus.s_set_coeffs) timeout_fail("wait_set");
  endtask

  task automatic wait_obs(input int nv, input int nc);
    int guard;
    guard = 0;
    while ((obs_v.size() < nv || obs_c.size() < nc) && guard < 60) begin
      tick();
      guard++;
    end
    if (obs_v.size() < nv || obs_c.size() < nc) timeout_fail("wait_obs");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    int pulses;
    reset_n          = 1'b0;
    bus.host_valid   = 1'b0;
    bus.host_is_coef = 1'b0;
    bus.host_data    = 6'd0;

    // Reset state
    tick();
    check("rst_x_n", 32'(bus.x_n), 32'd0);
    check("rst_tvalid", 32'(bus.s_axis_fir_tvalid), 32'd0);
    check("rst_set", 32'(bus.s_set_coeffs), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick();

    // Samples 5, -3, 7 back-to-back: first word two edges after first accept
    push(1'b0, 6'd5);
    check("lat_e0_tvalid", 32'(bus.s_axis_fir_tvalid), 32'd0);
    push(1'b0, 6'h3D);
    check("lat_e1_tvalid", 32'(bus.s_axis_fir_tvalid), 32'd0);
    push(1'b0, 6'd7);
    check("s0_x", 32'(bus.x_n), 32'h05);
    check("s0_tvalid", 32'(bus.s_axis_fir_tvalid), 32'd1);
    tick();
    check("s1_x", 32'(bus.x_n), 32'h3D);
    tick();
    check("s2_x", 32'(bus.x_n), 32'h07);
    tick();
`ifdef FIR_SRC_HOLD_LAST_EN
    check("s_end_x", 32'(bus.x_n), 32'h07);
    check("s_end_tvalid", 32'(bus.s_axis_fir_tvalid), 32'd1);
`else
    check("s_end_x", 32'(bus.x_n), 32'd0);
    check("s_end_tvalid", 32'(bus.s_axis_fir_tvalid), 32'd0);
`endif

    // Coefficient burst 0x15, 0x2A, 0x3F
    do_reset();
    push(1'b1, 6'h15);
    push(1'b1, 6'h2A);
    push(1'b1, 6'h3F);
    check("cfg_pend_busy", 32'(busy), 32'd1);
    wait_set(n);
    check("cfg_latency", 32'(n), 32'd2);
    check("cfg_w0", 32'(bus.x_n), 32'h15);
    check("cfg_w0_tvalid", 32'(bus.s_axis_fir_tvalid), 32'd0);
    tick();
    check("cfg_w1", 32'(bus.x_n), 32'h2A);
    tick();
    check("cfg_w2", 32'(bus.x_n), 32'h3F);
    check("cfg_w2_set", 32'(bus.s_set_coeffs), 32'd1);
    tick();
    check("cfg_gap_set", 32'(bus.s_set_coeffs), 32'd0);
    check("cfg_gap_x", 32'(bus.x_n), 32'd0);
    check("cfg_done_busy", 32'(busy), 32'd0);

    // Backpressure while the sink is held in a coefficient load
    do_reset();
    push(1'b1, 6'h01);
    push(1'b1, 6'h02);
    push(1'b1, 6'h03);
    for (int i = 1; i <= 4; i++) push(1'b0, 6'(i));
    check("bp_count", 32'(fifo_count), 32'd4);
    check("bp_in_cfg", 32'(bus.s_set_coeffs), 32'd1);
    bus.host_valid   = 1'b1;
    bus.host_is_coef = 1'b0;
    bus.host_data    = 6'd5;
    #1;
    check("bp_ready_low", 32'(bus.host_ready), 32'd0);
    push(1'b0, 6'd5);
    wait_obs(5, 0);
    for (int i = 0; i < 5; i++) check("bp_order", 32'(obs_v[i]), 32'(i + 1));

    // Coefficient burst completing mid-stream
    do_reset();
    push(1'b1, 6'h21);
    push(1'b1, 6'h22);
    for (int i = 0; i < 6; i++) push(1'b0, 6'(10 + i));
    push(1'b1, 6'h23);
    push(1'b0, 6'd16);
    push(1'b0, 6'd17);
    wait_obs(8, 3);
    for (int i = 0; i < 8; i++) check("mid_order", 32'(obs_v[i]), 32'(10 + i));
    for (int i = 0; i < 3; i++) check("mid_coef", 32'(obs_c[i]), 32'(33 + i));

    // Reset dropped during the second CFG cycle
    do_reset();
    push(1'b1, 6'h01);
    push(1'b1, 6'h02);
    push(1'b1, 6'h03);
    push(1'b0, 6'h11);
    push(1'b0, 6'h12);
    wait_set(n);
    tick();
    check("rc_pre_x", 32'(bus.x_n), 32'h02);
    #2;
    reset_n = 1'b0;
    #1;
    check("rc_x", 32'(bus.x_n), 32'd0);
    check("rc_set", 32'(bus.s_set_coeffs), 32'd0);
    check("rc_tvalid", 32'(bus.s_axis_fir_tvalid), 32'd0);
    check("rc_count", 32'(fifo_count), 32'd0);
    check("rc_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    pulses  = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.s_set_coeffs) pulses++;
    end
    check("rc_no_pulse", 32'(pulses), 32'd0);

`ifdef FIR_SRC_HOLD_LAST_EN
    // Hold-last: a lone sample stays on the sink
    do_reset();
    push(1'b0, 6'd9);
    repeat (20) tick();
    check("hold_x", 32'(bus.x_n), 32'd9);
    check("hold_tvalid", 32'(bus.s_axis_fir_tvalid), 32'd1);
    repeat (20) tick();
    check("hold_x_late", 32'(bus.x_n), 32'd9);
`endif

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
